// File: rtl/pulse_sync_arbiter_pkg.sv
// Shared types and default sizing for the pulse-sync arbiter.
// Holds the FSM state encoding and the parameter defaults.
// Also provides a small max helper used to size the shared timer.
package pulse_sync_pkg;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_CNT_W      = 3;
  localparam int DEF_GAP_CYCLES = 3;
  localparam int DEF_TIMEOUT    = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP,
    ST_WAIT_ACK
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pulse_sync_arbiter_rr.sv
// Round-robin picker: first set request at or after ptr, wrapping around.
// Latency: purely combinational.
// Backpressure: none; the caller decides when a grant is consumed.
module rr_arbiter
  import pulse_sync_pkg::*;
#(
  parameter int N     = DEF_NUM_REQ,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             vld
);

  int j;

  // Scan N positions starting at ptr; the first pending one wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    j   = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!vld && req[j]) begin
        vld    = 1'b1;
        gnt[j] = 1'b1;
        idx    = j[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/pulse_sync_arbiter.sv
// Serialises per-requester events onto one pulse channel with forced spacing and ack wait.
// Latency: strobe at edge t with idle arbiter -> o_pulse in the cycle after edge t+1.
// Backpressure: events queue in saturating per-requester counters; overflow is flagged sticky.
module pulse_sync_arbiter
  import pulse_sync_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic                       i_ack,
  input  logic                       i_ovf_clr,
  output logic                       o_pulse,
  output logic [$clog2(NUM_REQ)-1:0] o_id,
  output logic                       o_busy,
  output logic [NUM_REQ-1:0]         o_ovf,
  output logic                       o_timeout
);

  localparam int IDX_W = $clog2(NUM_REQ);
  // One down-counter serves both the GAP length and the WAIT_ACK timeout.
  localparam int TMR_W = $clog2(max_int(GAP_CYCLES, TIMEOUT) + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t                        state, state_nxt;
  logic [TMR_W-1:0]              tmr, tmr_nxt;
  logic                          timeout_nxt;
  logic [NUM_REQ-1:0][CNT_W-1:0] cnt;
  logic [NUM_REQ-1:0]            pend, arb_gnt, gnt, ovf_set;
  logic [IDX_W-1:0]              arb_idx, ptr;
  logic                          arb_vld, grant_fire;

  // A requester competes while its counter holds at least one event.
  always_comb begin
    pend    = '0;
    ovf_set = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pend[k]    = (cnt[k] != '0);
      ovf_set[k] = i_req[k] && !gnt[k] && (cnt[k] == CNT_MAX);
    end
  end

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req (pend),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .vld (arb_vld)
  );

  // Grants are only consumed from IDLE; elsewhere the arbiter result is ignored.
  assign grant_fire = (state == ST_IDLE) && arb_vld;
  assign gnt        = grant_fire ? arb_gnt : '0;

  assign o_pulse = (state == ST_SEND);
  assign o_busy  = (state != ST_IDLE);

  // Pending counters: increment on strobe, decrement on grant, saturate at max.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt <= '0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (i_req[k] && !gnt[k]) begin
          if (cnt[k] != CNT_MAX) cnt[k] <= cnt[k] + CNT_W'(1);
        end else if (!i_req[k] && gnt[k]) begin
          cnt[k] <= cnt[k] - CNT_W'(1);
        end
      end
    end
  end

  // Sticky overflow flags; a new overflow beats a same-cycle clear.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) o_ovf <= '0;
    else       o_ovf <= (i_ovf_clr ? '0 : o_ovf) | ovf_set;
  end

  // Latch the winner and move the round-robin start just past it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_id <= '0;
      ptr  <= '0;
    end else if (grant_fire) begin
      o_id <= arb_idx;
      ptr  <= (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
    end
  end

  // FSM state, shared timer and the registered timeout strobe.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      tmr       <= '0;
      o_timeout <= 1'b0;
    end else begin
      state     <= state_nxt;
      tmr       <= tmr_nxt;
      o_timeout <= timeout_nxt;
    end
  end

  // Next-state logic; ack wins over expiry in the last WAIT_ACK cycle.
  always_comb begin
    state_nxt   = state;
    tmr_nxt     = tmr;
    timeout_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (arb_vld) state_nxt = ST_SEND;
      end
      ST_SEND: begin
        state_nxt = ST_GAP;
        tmr_nxt   = TMR_W'(GAP_CYCLES - 1);
      end
      ST_GAP: begin
        if (tmr == '0) begin
          state_nxt = ST_WAIT_ACK;
          tmr_nxt   = TMR_W'(TIMEOUT - 1);
        end else begin
          tmr_nxt = tmr - TMR_W'(1);
        end
      end
      ST_WAIT_ACK: begin
        if (i_ack) begin
          state_nxt = ST_IDLE;
          tmr_nxt   = '0;
        end else if (tmr == '0) begin
          state_nxt   = ST_IDLE;
          timeout_nxt = 1'b1;
        end else begin
          tmr_nxt = tmr - TMR_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pulse_sync_arbiter.sv
// Directed bench for pulse_sync_arbiter with default parameters.
// Inputs change 1ns after the rising edge; outputs are sampled at the same point.
// Every scenario task checks its own expectations inline.
module tb_pulse_sync_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       ack;
  logic       ovf_clr;
  logic       pulse;
  logic [1:0] id;
  logic       busy;
  logic [3:0] ovf;
  logic       timeout;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_cnt  = 0;

  pulse_sync_arbiter dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_req     (req),
    .i_ack     (ack),
    .i_ovf_clr (ovf_clr),
    .o_pulse   (pulse),
    .o_id      (id),
    .o_busy    (busy),
    .o_ovf     (ovf),
    .o_timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc_cnt++;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; ack = 1'b0; ovf_clr = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_pulse(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      tick();
      if (pulse === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; ack = 1'b0; ovf_clr = 1'b0;
    #1;
    n_checks++; if (pulse !== 1'b0)   begin n_fail++; $display("FAIL reset_pulse: got %b want 0", pulse); end
    n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (id !== 2'd0)      begin n_fail++; $display("FAIL reset_id: got %0d want 0", id); end
    n_checks++; if (ovf !== 4'b0000)  begin n_fail++; $display("FAIL reset_ovf: got %b want 0000", ovf); end
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", timeout); end
    tick();
    tick();
    rst = 1'b0;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_ack_ignored: busy got %b want 0", busy); end
  endtask

  task automatic test_single();
    int pulses;
    do_reset();
    req = 4'b0100;
    tick();
    req = '0;
    n_checks++; if (pulse !== 1'b0) begin n_fail++; $display("FAIL single_early: pulse got %b want 0", pulse); end
    tick();
    n_checks++; if (pulse !== 1'b1) begin n_fail++; $display("FAIL single_pulse: got %b want 1", pulse); end
    n_checks++; if (id !== 2'd2)    begin n_fail++; $display("FAIL single_id: got %0d want 2", id); end
    n_checks++; if (busy !== 1'b1)  begin n_fail++; $display("FAIL single_busy: got %b want 1", busy); end
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (pulse === 1'b1) pulses++;
    end
    ack = 1'b1;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_at_ack: got %b want 1", busy); end
    tick();
    ack = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_fall: got %b want 0", busy); end
    n_checks++; if (id !== 2'd2)   begin n_fail++; $display("FAIL single_id_hold: got %0d want 2", id); end
    for (int c = 0; c < 8; c++) begin
      tick();
      if (pulse === 1'b1) pulses++;
    end
    n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL single_extra_pulses: got %0d want 0", pulses); end
  endtask

  task automatic test_round_robin();
    bit ok;
    int prev;
    int spacing;
    do_reset();
    req = 4'b1111;
    tick();
    req = '0;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_pulse(20, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL rr_pulse_%0d: no pulse within 20 cycles", k); end
      n_checks++; if (id !== k[1:0]) begin n_fail++; $display("FAIL rr_id_%0d: got %0d want %0d", k, id, k); end
      if (k > 0) begin
        spacing = cyc_cnt - prev;
        n_checks++; if (spacing < 5) begin n_fail++; $display("FAIL rr_spacing_%0d: got %0d want >= 5", k, spacing); end
      end
      prev = cyc_cnt;
      repeat (4) tick();
      ack = 1'b1;
      tick();
      ack = 1'b0;
    end
    wait_pulse(30, ok);
    n_checks++; if (ok) begin n_fail++; $display("FAIL rr_no_fifth: got pulse id %0d want none", id); end
  endtask

  task automatic test_overflow();
    bit ok;
    do_reset();
    req = 4'b0001;
    tick();
    req = '0;
    tick();
    req = 4'b0010;
    repeat (7) tick();
    n_checks++; if (dut.cnt[1] !== 3'd7) begin n_fail++; $display("FAIL ovf_cnt_full: got %0d want 7", dut.cnt[1]); end
    n_checks++; if (ovf !== 4'b0000)     begin n_fail++; $display("FAIL ovf_not_yet: got %b want 0000", ovf); end
    tick();
    n_checks++; if (ovf !== 4'b0010)     begin n_fail++; $display("FAIL ovf_set: got %b want 0010", ovf); end
    n_checks++; if (dut.cnt[1] !== 3'd7) begin n_fail++; $display("FAIL ovf_cnt_hold: got %0d want 7", dut.cnt[1]); end
    ovf_clr = 1'b1;
    tick();
    req = '0;
    n_checks++; if (ovf !== 4'b0010)     begin n_fail++; $display("FAIL ovf_set_beats_clr: got %b want 0010", ovf); end
    n_checks++; if (dut.cnt[1] !== 3'd7) begin n_fail++; $display("FAIL ovf_cnt_hold2: got %0d want 7", dut.cnt[1]); end
    tick();
    ovf_clr = 1'b0;
    n_checks++; if (ovf !== 4'b0000)     begin n_fail++; $display("FAIL ovf_clear: got %b want 0000", ovf); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    wait_pulse(5, ok);
    n_checks++; if (!ok || id !== 2'd1)  begin n_fail++; $display("FAIL ovf_next_grant: ok %0b id %0d want ok 1 id 1", ok, id); end
    n_checks++; if (dut.cnt[1] !== 3'd6) begin n_fail++; $display("FAIL ovf_cnt_after_grant: got %0d want 6", dut.cnt[1]); end
  endtask

  task automatic test_timeout();
    int early;
    do_reset();
    req = 4'b0101;
    tick();
    req = '0;
    tick();
    n_checks++; if (pulse !== 1'b1 || id !== 2'd0) begin n_fail++; $display("FAIL to_first: pulse %b id %0d want 1 0", pulse, id); end
    repeat (4) tick();
    early = 0;
    for (int c = 0; c < 63; c++) begin
      tick();
      if (timeout === 1'b1) early++;
    end
    n_checks++; if (early !== 0)      begin n_fail++; $display("FAIL to_early: got %0d strobes want 0", early); end
    n_checks++; if (busy !== 1'b1)    begin n_fail++; $display("FAIL to_still_waiting: busy got %b want 1", busy); end
    tick();
    n_checks++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL to_strobe: got %b want 1", timeout); end
    n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL to_idle: busy got %b want 0", busy); end
    tick();
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL to_single_cycle: got %b want 0", timeout); end
    n_checks++; if (pulse !== 1'b1 || id !== 2'd2) begin n_fail++; $display("FAIL to_next_served: pulse %b id %0d want 1 2", pulse, id); end
  endtask

  task automatic test_ack_race();
    do_reset();
    req = 4'b0001;
    tick();
    req = '0;
    tick();
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL race_stray_ack: busy got %b want 1", busy); end
    tick();
    tick();
    repeat (63) tick();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL race_final_cycle: busy got %b want 1", busy); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL race_no_timeout: got %b want 0", timeout); end
    n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL race_idle: busy got %b want 0", busy); end
    tick();
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL race_no_timeout_late: got %b want 0", timeout); end
  endtask

  task automatic test_reset_mid_gap();
    int bad;
    do_reset();
    req = 4'b1110;
    tick();
    req = 4'b0001;
    tick();
    req = '0;
    n_checks++; if (pulse !== 1'b1 || id !== 2'd1) begin n_fail++; $display("FAIL rmg_setup: pulse %b id %0d want 1 1", pulse, id); end
    tick();
    #2;
    rst = 1'b1;
    ack = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL rmg_busy: got %b want 0", busy); end
    n_checks++; if (pulse !== 1'b0)   begin n_fail++; $display("FAIL rmg_pulse: got %b want 0", pulse); end
    n_checks++; if (id !== 2'd0)      begin n_fail++; $display("FAIL rmg_id: got %0d want 0", id); end
    n_checks++; if (ovf !== 4'b0000 || timeout !== 1'b0) begin n_fail++; $display("FAIL rmg_flags: ovf %b timeout %b want 0000 0", ovf, timeout); end
    n_checks++; if (dut.cnt !== 12'd0) begin n_fail++; $display("FAIL rmg_counters: got %h want 000", dut.cnt); end
    tick();
    tick();
    rst = 1'b0;
    tick();
    ack = 1'b0;
    bad = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (pulse !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL rmg_quiet: got %0d active cycles want 0", bad); end
    req = 4'b1000;
    tick();
    req = '0;
    n_checks++; if (pulse !== 1'b0) begin n_fail++; $display("FAIL rmg_new_early: pulse got %b want 0", pulse); end
    tick();
    n_checks++; if (pulse !== 1'b1 || id !== 2'd3) begin n_fail++; $display("FAIL rmg_new_pulse: pulse %b id %0d want 1 3", pulse, id); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_overflow();
    test_timeout();
    test_ack_race();
    test_reset_mid_gap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded 200000ns");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pulse_sync_arbiter.md
PULSE_SYNC_ARBITER -- requirements
Module: pulse_sync_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of event requesters sharing one pulse-sync channel (2..8).
REQ-002 Parameter CNT_W, default 3: width of each per-requester pending-event counter.
REQ-003 Parameter GAP_CYCLES, default 3: idle cycles forced after each issued pulse (GAP_CYCLES >= 1).
REQ-004 Parameter TIMEOUT, default 64: maximum cycles in WAIT_ACK before abandoning (TIMEOUT >= 2).
REQ-005 One clock and one reset: i_clk is the sole clock; i_rst is asynchronous, active-high.
REQ-006 i_clk  in  1  block clock (source domain of the shared pulse channel).
REQ-007 i_rst  in  1  asynchronous active-high reset.
REQ-008 i_req  in  NUM_REQ  per-requester single-cycle event strobes.
REQ-009 i_ack  in  1  single-cycle acknowledge, already synchronized into i_clk domain.
REQ-010 i_ovf_clr  in  1  synchronous clear of all o_ovf bits.
REQ-011 o_pulse  out  1  single-cycle event pulse toward the pulse synchronizer.
REQ-012 o_id  out  clog2(NUM_REQ)  requester index of the current/last issued pulse.
REQ-013 o_busy  out  1  high whenever state is not IDLE.
REQ-014 o_ovf  out  NUM_REQ  sticky per-requester pending-counter overflow flags.
REQ-015 o_timeout  out  1  single-cycle strobe when WAIT_ACK expires.

Function
REQ-016 Each requester owns a CNT_W-bit pending counter: +1 on i_req[k], -1 on grant to k.
REQ-017 Simultaneous i_req[k] and grant to k leave counter k unchanged.
REQ-018 Counter at 2^CNT_W-1 with i_req[k] and no grant: count holds, o_ovf[k] sets on the next edge.
REQ-019 o_ovf[k] stays set until i_ovf_clr; a set and a clear in the same cycle resolve to set.
REQ-020 FSM states: IDLE, SEND, GAP, WAIT_ACK.
REQ-021 IDLE: if any counter > 0, grant round-robin winner, latch o_id, go to SEND; else stay.
REQ-022 Round-robin search starts at the index after the last grant; after reset it starts at index 0.
REQ-023 SEND lasts exactly one cycle with o_pulse=1; o_pulse is 0 in every other state; next state is GAP.
REQ-024 GAP lasts exactly GAP_CYCLES cycles, then WAIT_ACK.
REQ-025 WAIT_ACK: i_ack=1 -> IDLE on the next edge; after TIMEOUT cycles without i_ack -> IDLE with o_timeout=1 for one cycle.
REQ-026 A timed-out event is dropped (not re-queued); its counter was already decremented at grant.
REQ-027 i_ack outside WAIT_ACK is ignored; i_ack in the final WAIT_ACK cycle takes priority over timeout.
REQ-028 Latency: i_req[k] sampled at edge t with arbiter idle and all counters 0 -> o_pulse=1 in the cycle after edge t+1.
REQ-029 Minimum pulse spacing is 1+GAP_CYCLES+1 cycles, which guarantees no pulse merge at the synchronizer.

Reset
REQ-030 i_rst asserted sets state=IDLE, all counters=0, o_ovf=0, o_pulse=0, o_timeout=0, o_id=0, RR pointer=0, timers=0, asynchronously.
REQ-031 Reset mid-operation discards all pending events and any in-flight acknowledge; an i_ack in the first cycle after reset release is ignored.

Structure
REQ-032 Package pulse_sync_pkg holds the FSM state enum and default values of NUM_REQ, CNT_W, GAP_CYCLES and TIMEOUT.
REQ-033 Sub-module rr_arbiter (request vector, pointer -> one-hot grant plus index) is instantiated once; counters, FSM and timers reside in the top module.
REQ-034 The GAP counter and the WAIT_ACK timer share a single down-counter sized for max(GAP_CYCLES, TIMEOUT).

Verification
REQ-035 Single event: i_req=4'b0100 for 1 cycle, i_ack 5 cycles after o_pulse -> one o_pulse, o_id=2, o_busy falls 1 cycle after i_ack.
REQ-036 Round-robin: i_req=4'b1111 for 1 cycle, acks returned promptly -> o_id sequence 0,1,2,3, pulse spacing >= 5 cycles.
REQ-037 Overflow: i_req[1] strobed 9 times while arbiter waits on ack -> o_ovf=4'b0010, counter held at 7; i_ovf_clr -> o_ovf=0.
REQ-038 Timeout: no i_ack -> o_timeout=1 exactly 64 cycles after entering WAIT_ACK, then the next pending requester is served.
REQ-039 Ack race: i_ack in the final WAIT_ACK cycle -> no o_timeout; stray i_ack in GAP ignored and arbiter still waits.
REQ-040 Reset mid-GAP with 3 events pending -> all outputs 0 immediately, no o_pulse after release until new i_req.
